// File: rtl/commu_pkg.sv
// Shared state encodings and sizing helpers for the frame transmit scheduler.
// The optional watchdog is enabled by defining COMMU_WDOG_EN.
package commu_pkg;

  localparam logic [3:0] S_IDLE   = 4'h0;
  localparam logic [3:0] S_ARB    = 4'h1;
  localparam logic [3:0] S_FIRE_H = 4'h2;
  localparam logic [3:0] S_WAIT_H = 4'h3;
  localparam logic [3:0] S_FIRE_P = 4'h4;
  localparam logic [3:0] S_WAIT_P = 4'h5;
  localparam logic [3:0] S_FIRE_T = 4'h6;
  localparam logic [3:0] S_WAIT_T = 4'h7;
  localparam logic [3:0] S_FAIL   = 4'he;
  localparam logic [3:0] S_DONE   = 4'hf;

  localparam int RETRY_W = 4;

  // Counter width that can hold WDOG_CYC-1.
  function automatic int wdog_w(input int cyc);
    return (cyc <= 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/commu_rr_arb.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
// Part of the commu_sched slice (watchdog option: COMMU_WDOG_EN, not used here).
module commu_rr_arb
  import commu_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [PTR_W-1:0] win_idx
);

  always_comb begin
    int  idx;
    logic found;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/commu_sched.sv
// Round-robin scheduler sharing the head/push/tail transmit sequencer among NREQ requesters.
// Define COMMU_WDOG_EN to add the per-WAIT watchdog with bounded sequence restarts.
module commu_sched
  import commu_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WDOG_CYC  = 1024,
  parameter int MAX_RETRY = 3
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] ack,
  output logic [NREQ-1:0] err,
  input  logic            pk_frm,
  output logic            fire_head,
  output logic            fire_push,
  output logic            fire_tail,
  input  logic            done_head,
  input  logic            done_push,
  input  logic            done_tail,
  output logic            busy
);

  localparam int PTR_W = $clog2(NREQ);

  logic [3:0]       state_reg, state_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [NREQ-1:0]  ack_reg;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic             fire_head_reg, fire_push_reg, fire_tail_reg, busy_reg;
  logic [NREQ-1:0]  win;
  logic [PTR_W-1:0] win_idx;
  logic             to_restart, to_fail;
  logic             in_wait;

  commu_rr_arb #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .req     (req),
    .ptr     (ptr_reg),
    .win     (win),
    .win_idx (win_idx)
  );

  assign in_wait = (state_reg == S_WAIT_H) || (state_reg == S_WAIT_P) ||
                   (state_reg == S_WAIT_T);

`ifdef COMMU_WDOG_EN
  localparam int WDOG_W = wdog_w(WDOG_CYC);

  logic [WDOG_W-1:0]  wdog_reg;
  logic [RETRY_W-1:0] retry_reg;
  logic [NREQ-1:0]    err_reg;
  logic               timeout;

  assign timeout    = in_wait && (wdog_reg == WDOG_W'(WDOG_CYC - 1));
  assign to_restart = timeout && (retry_reg < RETRY_W'(MAX_RETRY));
  assign to_fail    = timeout && !to_restart;

  // Watchdog is zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wdog_reg  <= '0;
      retry_reg <= '0;
      err_reg   <= '0;
    end else begin
      wdog_reg <= in_wait ? wdog_reg + 1'b1 : '0;
      if (state_next == S_DONE || state_next == S_FAIL)
        retry_reg <= '0;
      else if (in_wait && state_next == S_FIRE_H)
        retry_reg <= retry_reg + 1'b1;
      err_reg <= (state_next == S_FAIL) ? gnt_reg : '0;
    end
  end

  assign err = err_reg;
`else
  assign to_restart = 1'b0;
  assign to_fail    = 1'b0;
  assign err        = '0;
`endif

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      S_IDLE: if (|req && !pk_frm) state_next = S_ARB;
      S_ARB: begin
        if (|req) begin
          gnt_next   = win;
          ptr_next   = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          state_next = S_FIRE_H;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_FIRE_H: state_next = S_WAIT_H;
      S_FIRE_P: state_next = S_WAIT_P;
      S_FIRE_T: state_next = S_WAIT_T;
      S_WAIT_H: begin
        if (done_head)       state_next = S_FIRE_P;
        else if (to_restart) state_next = S_FIRE_H;
        else if (to_fail)    state_next = S_FAIL;
      end
      S_WAIT_P: begin
        if (done_push)       state_next = S_FIRE_T;
        else if (to_restart) state_next = S_FIRE_H;
        else if (to_fail)    state_next = S_FAIL;
      end
      S_WAIT_T: begin
        if (done_tail)       state_next = S_DONE;
        else if (to_restart) state_next = S_FIRE_H;
        else if (to_fail)    state_next = S_FAIL;
      end
      S_DONE, S_FAIL: begin
        gnt_next   = '0;
        state_next = S_IDLE;
      end
      default: begin
        gnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      gnt_reg       <= '0;
      ptr_reg       <= '0;
      ack_reg       <= '0;
      fire_head_reg <= 1'b0;
      fire_push_reg <= 1'b0;
      fire_tail_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      ptr_reg       <= ptr_next;
      ack_reg       <= (state_next == S_DONE) ? gnt_reg : '0;
      fire_head_reg <= (state_next == S_FIRE_H);
      fire_push_reg <= (state_next == S_FIRE_P);
      fire_tail_reg <= (state_next == S_FIRE_T);
      busy_reg      <= (state_next != S_IDLE);
    end
  end

  assign gnt       = gnt_reg;
  assign ack       = ack_reg;
  assign fire_head = fire_head_reg;
  assign fire_push = fire_push_reg;
  assign fire_tail = fire_tail_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_commu_sched.sv
// Table-driven bench for commu_sched with a done-responder model and hand sequences.
// Watchdog rows run only when COMMU_WDOG_EN is defined.
module tb_commu_sched;

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       pk_frm = 1'b0;
  logic       done_head = 1'b0, done_push = 1'b0, done_tail = 1'b0;
  logic [3:0] gnt, ack, err;
  logic       fire_head, fire_push, fire_tail, busy;

  always #5 clk_sys = ~clk_sys;

  commu_sched #(.NREQ(4), .WDOG_CYC(16), .MAX_RETRY(2)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .ack       (ack),
    .err       (err),
    .pk_frm    (pk_frm),
    .fire_head (fire_head),
    .fire_push (fire_push),
    .fire_tail (fire_tail),
    .done_head (done_head),
    .done_push (done_push),
    .done_tail (done_tail),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0] req;
    int         lat;
    bit         p_en;
    int         p_arm;
    bit         drop;
    logic [3:0] exp_gnt;
    logic [3:0] exp_ack;
    logic [3:0] exp_err;
    int         exp_fh, exp_fp, exp_ft;
    int         exp_fh_idx, exp_end_idx;
  } vec_t;

  vec_t vecs[$];
  vec_t wvecs[$];
  int   checks = 0;
  int   errors = 0;

  // Responder: done_x pulses resp_lat cycles after fire_x, gated per phase.
  int       resp_lat = 1;
  bit [2:0] resp_en = 3'b111;
  int       cnt[3] = '{-1, -1, -1};
  wire [2:0] fires = {fire_tail, fire_push, fire_head};

  always @(negedge clk_sys) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) cnt[i] = -1;
      else if (fires[i]) cnt[i] = resp_lat;
      else if (cnt[i] >= 0) cnt[i] = cnt[i] - 1;
    end
    done_head = (cnt[0] == 0) && resp_en[0];
    done_push = (cnt[1] == 0) && resp_en[1];
    done_tail = (cnt[2] == 0) && resp_en[2];
  end

  // Monitor: per-transaction statistics sampled just after each edge.
  int         fh_cnt, fp_cnt, ft_cnt, cyc_idx, fh_idx, bad_gnt, p_arm;
  logic [3:0] seen_gnt;

  always @(posedge clk_sys) begin
    #1;
    cyc_idx++;
    if (fire_head) begin
      fh_cnt++;
      if (fh_idx < 0) fh_idx = cyc_idx;
      if (p_arm != 0 && fh_cnt == p_arm) resp_en[1] = 1'b1;
    end
    if (fire_push) fp_cnt++;
    if (fire_tail) ft_cnt++;
    if (!$onehot0(gnt)) bad_gnt++;
    if (gnt != 4'b0000) begin
      if (seen_gnt == 4'b0000) seen_gnt = gnt;
      else if (gnt != seen_gnt) bad_gnt++;
    end
  end

  task automatic clear_stats();
    fh_cnt = 0; fp_cnt = 0; ft_cnt = 0; cyc_idx = 0;
    fh_idx = -1; bad_gnt = 0; seen_gnt = 4'b0000;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(ref vec_t q[$], input logic [3:0] r, input int lat, input bit p_en,
                         input int p_arm_at, input bit drop, input logic [3:0] eg,
                         input logic [3:0] ea, input logic [3:0] ee, input int fh,
                         input int fp, input int ft, input int fhi, input int endi);
    vec_t v;
    v.req = r; v.lat = lat; v.p_en = p_en; v.p_arm = p_arm_at; v.drop = drop;
    v.exp_gnt = eg; v.exp_ack = ea; v.exp_err = ee;
    v.exp_fh = fh; v.exp_fp = fp; v.exp_ft = ft;
    v.exp_fh_idx = fhi; v.exp_end_idx = endi;
    q.push_back(v);
  endtask

  task automatic apply_row(input vec_t v, input string nm);
    int         cyc;
    bit         fin;
    logic [3:0] ack_s, err_s;
    resp_lat = v.lat;
    resp_en  = {1'b1, v.p_en, 1'b1};
    p_arm    = v.p_arm;
    clear_stats();
    req = v.req;
    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < 400) begin
      @(negedge clk_sys);
      cyc++;
      if (ack != 4'b0000 || err != 4'b0000) fin = 1'b1;
    end
    ack_s = ack;
    err_s = err;
    chk({nm, " completed"}, int'(fin), 1);
    chk({nm, " gnt"}, int'(seen_gnt), int'(v.exp_gnt));
    chk({nm, " ack"}, int'(ack_s), int'(v.exp_ack));
    chk({nm, " err"}, int'(err_s), int'(v.exp_err));
    chk({nm, " fire_head count"}, fh_cnt, v.exp_fh);
    chk({nm, " fire_push count"}, fp_cnt, v.exp_fp);
    chk({nm, " fire_tail count"}, ft_cnt, v.exp_ft);
    if (v.exp_fh_idx >= 0) chk({nm, " fire_head latency"}, fh_idx, v.exp_fh_idx);
    if (v.exp_end_idx >= 0) chk({nm, " sequence length"}, cyc, v.exp_end_idx);
    $display("txn %s req=%b gnt=%b ack=%b err=%b fires=%0d/%0d/%0d cycles=%0d",
             nm, v.req, seen_gnt, ack_s, err_s, fh_cnt, fp_cnt, ft_cnt, cyc);
    if (v.drop) req = 4'b0000;
    @(negedge clk_sys);
    chk({nm, " single pulse"}, int'(ack | err), 0);
    chk({nm, " busy after end"}, int'(busy), 0);
    chk({nm, " gnt cleared"}, int'(gnt), 0);
    chk({nm, " gnt one-hot stable"}, bad_gnt, 0);
  endtask

  initial begin
    int cyc;
    bit seen;
    clear_stats();
    p_arm = 0;

    // req, lat, p_en, p_arm, drop, gnt, ack, err, fh, fp, ft, fh_idx, end_idx
    add_vec(vecs, 4'b1111, 1, 1'b1, 0, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1, 1, 1, 2, 8);
    add_vec(vecs, 4'b1111, 1, 1'b1, 0, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 1, 2, 8);
    add_vec(vecs, 4'b1111, 1, 1'b1, 0, 1'b0, 4'b0100, 4'b0100, 4'b0000, 1, 1, 1, 2, 8);
    add_vec(vecs, 4'b1111, 1, 1'b1, 0, 1'b0, 4'b1000, 4'b1000, 4'b0000, 1, 1, 1, 2, 8);
    add_vec(vecs, 4'b1111, 1, 1'b1, 0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1, 1, 1, 2, 8);
    add_vec(vecs, 4'b0001, 2, 1'b1, 0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1, 1, 1, 2, 11);
`ifdef COMMU_WDOG_EN
    add_vec(wvecs, 4'b0100, 1, 1'b0, 0, 1'b1, 4'b0100, 4'b0000, 4'b0100, 3, 3, 0, 2, -1);
    add_vec(wvecs, 4'b1000, 1, 1'b0, 2, 1'b1, 4'b1000, 4'b1000, 4'b0000, 2, 2, 1, 2, -1);
    add_vec(wvecs, 4'b0001, 1, 1'b0, 0, 1'b1, 4'b0001, 4'b0000, 4'b0001, 3, 3, 0, 2, -1);
`endif

    repeat (3) @(negedge clk_sys);
    chk("reset outputs", int'({gnt, ack, err, fire_head, fire_push, fire_tail, busy}), 0);
    rst_n = 1'b1;
    @(negedge clk_sys);

    foreach (vecs[i]) apply_row(vecs[i], $sformatf("row%0d", i));

    // Inbound frame holds off arbitration.
    pk_frm = 1'b1;
    req = 4'b0010;
    clear_stats();
    repeat (20) @(negedge clk_sys);
    chk("pk_frm blocks fire_head", fh_cnt, 0);
    chk("pk_frm keeps idle", int'(busy), 0);
    $display("txn pk_hold req=%b fires=%0d busy=%b", req, fh_cnt, busy);
    pk_frm = 1'b0;
    begin
      vec_t v;
      v.req = 4'b0010; v.lat = 1; v.p_en = 1'b1; v.p_arm = 0; v.drop = 1'b1;
      v.exp_gnt = 4'b0010; v.exp_ack = 4'b0010; v.exp_err = 4'b0000;
      v.exp_fh = 1; v.exp_fp = 1; v.exp_ft = 1; v.exp_fh_idx = 2; v.exp_end_idx = 8;
      apply_row(v, "pk_release");
    end

    // Reset while waiting on push aborts silently and restarts arbitration at 0.
    resp_en = 3'b101;
    p_arm = 0;
    req = 4'b0001;
    clear_stats();
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 50) begin
      @(negedge clk_sys);
      cyc++;
      if (fire_push) seen = 1'b1;
    end
    chk("reach WAIT_P", int'(seen), 1);
    @(negedge clk_sys);
    rst_n = 1'b0;
    @(negedge clk_sys);
    chk("mid reset gnt", int'(gnt), 0);
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset ack/err", int'(ack | err), 0);
    $display("txn reset_in_wait_p gnt=%b busy=%b ack=%b err=%b", gnt, busy, ack, err);
    rst_n = 1'b1;
    begin
      vec_t v;
      v.req = 4'b1111; v.lat = 1; v.p_en = 1'b1; v.p_arm = 0; v.drop = 1'b1;
      v.exp_gnt = 4'b0001; v.exp_ack = 4'b0001; v.exp_err = 4'b0000;
      v.exp_fh = 1; v.exp_fp = 1; v.exp_ft = 1; v.exp_fh_idx = 2; v.exp_end_idx = 8;
      apply_row(v, "post_reset");
    end

    foreach (wvecs[i]) apply_row(wvecs[i], $sformatf("wdog%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
